// File: rtl/mask_window_counter_pkg.sv
// rtl/mask_window_counter_pkg.sv - state encoding and window-counter sizing for mask_window_counter
package mask_window_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // The counter only ever holds WINDOW-1 down to 0, so clog2(WINDOW) bits suffice.
    function automatic int win_cnt_w(input int window);
        int w;
        w = $clog2(window);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mask_window_counter_if.sv
// rtl/mask_window_counter_if.sv - control/data bundle for mask_window_counter (MASK_WINDOW_OVF_EN adds ovf)
interface mask_window_counter_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic                     start;
    logic                     b;
    logic                     c;
    logic [WIDTH-1:0]         d;
    logic [WIDTH-1:0]         a_q;
    logic                     busy;
    logic                     done;
    logic [WIDTH*CNT_W-1:0]   cnt_bus;
`ifdef MASK_WINDOW_OVF_EN
    logic [WIDTH-1:0]         ovf;

    modport master (output start, b, c, d, input a_q, busy, done, cnt_bus, ovf);
    modport slave  (input start, b, c, d, output a_q, busy, done, cnt_bus, ovf);
`else
    modport master (output start, b, c, d, input a_q, busy, done, cnt_bus);
    modport slave  (input start, b, c, d, output a_q, busy, done, cnt_bus);
`endif
endinterface

// File: rtl/mask_edge_counter.sv
// rtl/mask_edge_counter.sv - saturating rising-edge counter for one mask bit (MASK_WINDOW_OVF_EN adds ovf)
module mask_edge_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] cnt
`ifdef MASK_WINDOW_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic prev;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            prev <= 1'b0;
            cnt  <= '0;
`ifdef MASK_WINDOW_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (en) begin
            prev <= bit_in;
            if (bit_in && !prev) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
`ifdef MASK_WINDOW_OVF_EN
                else begin
                    ovf <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/mask_window_counter.sv
// rtl/mask_window_counter.sv - windowed per-bit rising-edge counter on {b, ~c} & d (MASK_WINDOW_OVF_EN adds ovf)
module mask_window_counter
    import mask_window_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    mask_window_counter_if.slave  bus
);

    localparam int              WC_W    = win_cnt_w(WINDOW);
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(WINDOW - 1);

    state_t                 state;
    logic [WC_W-1:0]        win_cnt;
    logic [WIDTH-1:0]       m;
    logic                   clr;
    logic                   en;
    logic [WIDTH*CNT_W-1:0] cnt_all;

    assign m   = {bus.b, {(WIDTH-1){~bus.c}}} & bus.d;
    assign clr = (state == IDLE) && bus.start;
    assign en  = (state == RUN);

    assign bus.cnt_bus = cnt_all;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            win_cnt  <= '0;
            bus.a_q  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.a_q  <= m;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        win_cnt  <= WC_LOAD;
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    // A zero count marks the last sampled cycle of the window.
                    if (win_cnt == '0) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef MASK_WINDOW_OVF_EN
    logic [WIDTH-1:0] ovf_all;
    assign bus.ovf = ovf_all;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mask_edge_counter #(.CNT_W(CNT_W)) u_edge (
            .clock  (clock),
            .reset  (reset),
            .clr    (clr),
            .en     (en),
            .bit_in (m[i]),
            .cnt    (cnt_all[i*CNT_W +: CNT_W])
`ifdef MASK_WINDOW_OVF_EN
            ,
            .ovf    (ovf_all[i])
`endif
        );
    end

endmodule

// File: tb/tb_mask_window_counter.sv
// tb/tb_mask_window_counter.sv - randomized self-checking bench for mask_window_counter (MASK_WINDOW_OVF_EN aware)
module tb_mask_window_counter;

    localparam int W     = 2;
    localparam int DEPTH = 1024;
    localparam int WIN [3] = '{16, 16, 1};
    localparam int CW  [3] = '{8, 2, 8};

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         b;
    logic         c;
    logic [W-1:0] d;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [W-1:0] m_hist [DEPTH];
    logic [W-1:0] aq_o   [3][DEPTH];
    logic         busy_o [3][DEPTH];
    logic         done_o [3][DEPTH];
    logic [15:0]  cnt_o  [3][DEPTH];
`ifdef MASK_WINDOW_OVF_EN
    logic [W-1:0] ovf_o  [3][DEPTH];
`endif

    mask_window_counter_if #(.WIDTH(W), .CNT_W(8)) if_main ();
    mask_window_counter_if #(.WIDTH(W), .CNT_W(2)) if_sat  ();
    mask_window_counter_if #(.WIDTH(W), .CNT_W(8)) if_w1   ();

    assign if_main.start = start;
    assign if_main.b     = b;
    assign if_main.c     = c;
    assign if_main.d     = d;
    assign if_sat.start  = start;
    assign if_sat.b      = b;
    assign if_sat.c      = c;
    assign if_sat.d      = d;
    assign if_w1.start   = start;
    assign if_w1.b       = b;
    assign if_w1.c       = c;
    assign if_w1.d       = d;

    mask_window_counter #(.WIDTH(W), .CNT_W(8), .WINDOW(16)) u_main (.clock(clock), .reset(reset), .bus(if_main));
    mask_window_counter #(.WIDTH(W), .CNT_W(2), .WINDOW(16)) u_sat  (.clock(clock), .reset(reset), .bus(if_sat));
    mask_window_counter #(.WIDTH(W), .CNT_W(8), .WINDOW(1))  u_w1   (.clock(clock), .reset(reset), .bus(if_w1));

    always #5 clock = ~clock;

    // Top bit gated by b, all lower bits gated by the complement of c.
    function automatic logic [W-1:0] ref_mask(input logic bb, input logic cc, input logic [W-1:0] dd);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = dd[i] & ((i == W-1) ? bb : ~cc);
        end
        return r;
    endfunction

    function automatic int raw_edges(input int k, input int w, input int bi);
        int n = 0;
        for (int j = k + 1; j <= k + w; j++) begin
            if (m_hist[j][bi] && (j == k + 1 || !m_hist[j-1][bi])) n++;
        end
        return n;
    endfunction

    function automatic logic [15:0] exp_bus(input int k, input int w, input int cw);
        logic [15:0] r = '0;
        int          n;
        int          mx;
        mx = (1 << cw) - 1;
        for (int bi = 0; bi < W; bi++) begin
            n = raw_edges(k, w, bi);
            if (n > mx) n = mx;
            r = r | (16'(n) << (bi * cw));
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_ovf(input int k, input int w, input int cw);
        logic [W-1:0] r;
        for (int bi = 0; bi < W; bi++) r[bi] = (raw_edges(k, w, bi) > (1 << cw) - 1);
        return r;
    endfunction

    task automatic tick();
        m_hist[cyc] = ref_mask(b, c, d);
        @(posedge clock);
        #1;
        cyc++;
        if (cyc >= DEPTH) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, DEPTH);
            $fatal(1);
        end
        aq_o[0][cyc]   = if_main.a_q;
        aq_o[1][cyc]   = if_sat.a_q;
        aq_o[2][cyc]   = if_w1.a_q;
        busy_o[0][cyc] = if_main.busy;
        busy_o[1][cyc] = if_sat.busy;
        busy_o[2][cyc] = if_w1.busy;
        done_o[0][cyc] = if_main.done;
        done_o[1][cyc] = if_sat.done;
        done_o[2][cyc] = if_w1.done;
        cnt_o[0][cyc]  = 16'(if_main.cnt_bus);
        cnt_o[1][cyc]  = 16'(if_sat.cnt_bus);
        cnt_o[2][cyc]  = 16'(if_w1.cnt_bus);
`ifdef MASK_WINDOW_OVF_EN
        ovf_o[0][cyc]  = if_main.ovf;
        ovf_o[1][cyc]  = if_sat.ovf;
        ovf_o[2][cyc]  = if_w1.ovf;
`endif
    endtask

    // mode 0: idle mask, 1: full mask held, 2: toggle 3/0 from first RUN cycle, 3: random
    task automatic drive(input int mode, input int j);
        case (mode)
            0: begin b = 1'b0; c = 1'b1; d = W'($urandom); end
            1: begin b = 1'b1; c = 1'b0; d = '1; end
            2: begin b = 1'b1; c = 1'b0; d = (j % 2 == 1) ? '1 : '0; end
            default: begin b = 1'($urandom); c = 1'($urandom_range(0, 3) == 0); d = W'($urandom); end
        endcase
    endtask

    task automatic run_window(input int mode, input int p1, input int p2, output int k);
        k = cyc;
        for (int j = 0; j < 20; j++) begin
            drive(mode, j);
            start = (j == 0) || (p1 > 0 && j == p1) || (p2 > 0 && j == p2);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; b = 1'b0; c = 1'b0; d = '0;
        tick();
        tick();
        for (int x = 0; x < 3; x++) begin
            vecs++;
            if ({aq_o[x][cyc], busy_o[x][cyc], done_o[x][cyc], cnt_o[x][cyc]} !== '0) begin
                errs++;
                $display("FAIL reset_state dut%0d: got a_q=%h busy=%b done=%b cnt=%h, expected all zero",
                         x, aq_o[x][cyc], busy_o[x][cyc], done_o[x][cyc], cnt_o[x][cyc]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_idle_mask();
        int k;
        int k0;
        k0 = cyc;
        for (int j = 0; j < 4; j++) begin
            drive(0, j);
            tick();
        end
        run_window(0, 0, 0, k);
        for (int n = k0 + 1; n <= cyc; n++) begin
            vecs++;
            if (aq_o[0][n] !== '0) begin
                errs++;
                $display("FAIL idle_mask_aq cyc%0d: got %h expected 0", n, aq_o[0][n]);
            end
        end
        vecs++;
        if (done_o[0][k+17] !== 1'b1 || cnt_o[0][k+17] !== 16'h0) begin
            errs++;
            $display("FAIL idle_mask_cnt: got done=%b cnt=%h expected done=1 cnt=0000", done_o[0][k+17], cnt_o[0][k+17]);
        end
    endtask

    task automatic test_full_mask();
        int k;
        int nb;
        int nd;
        run_window(1, 0, 0, k);
        nb = 0;
        nd = 0;
        for (int n = k + 1; n <= k + 20; n++) begin
            nb += int'(busy_o[0][n]);
            nd += int'(done_o[0][n]);
        end
        vecs++;
        if (nb != 16 || nd != 1 || done_o[0][k+17] !== 1'b1) begin
            errs++;
            $display("FAIL full_mask_timing: got busy_cycles=%0d dones=%0d done@k+17=%b expected 16 1 1", nb, nd, done_o[0][k+17]);
        end
        vecs++;
        if (cnt_o[0][k+17] !== 16'h0101) begin
            errs++;
            $display("FAIL full_mask_cnt: got %h expected 0101", cnt_o[0][k+17]);
        end
        vecs++;
        if (done_o[2][k+2] !== 1'b1 || busy_o[2][k+1] !== 1'b1 || busy_o[2][k+2] !== 1'b0 || cnt_o[2][k+2] !== 16'h0101) begin
            errs++;
            $display("FAIL window1: got done@k+2=%b busy@k+1=%b cnt=%h expected 1 1 0101",
                     done_o[2][k+2], busy_o[2][k+1], cnt_o[2][k+2]);
        end
    endtask

    task automatic test_toggle_saturation();
        int k;
        run_window(2, 0, 0, k);
        vecs++;
        if (cnt_o[0][k+17] !== 16'h0808) begin
            errs++;
            $display("FAIL toggle_cnt: got %h expected 0808", cnt_o[0][k+17]);
        end
        vecs++;
        if (cnt_o[1][k+17] !== 16'h000f) begin
            errs++;
            $display("FAIL saturate_cnt: got %h expected 000f", cnt_o[1][k+17]);
        end
`ifdef MASK_WINDOW_OVF_EN
        vecs++;
        if (ovf_o[1][k+17] !== 2'b11 || ovf_o[0][k+17] !== 2'b00) begin
            errs++;
            $display("FAIL ovf: got sat=%b main=%b expected 11 00", ovf_o[1][k+17], ovf_o[0][k+17]);
        end
`endif
    endtask

    task automatic test_random();
        int k;
        for (int r = 0; r < 4; r++) begin
            run_window(3, 0, 0, k);
            for (int x = 0; x < 3; x++) begin
                for (int n = k + 1; n <= k + 20; n++) begin
                    vecs++;
                    if (busy_o[x][n] !== (n <= k + WIN[x]) || done_o[x][n] !== (n == k + WIN[x] + 1)) begin
                        errs++;
                        $display("FAIL rand_ctrl dut%0d cyc%0d: got busy=%b done=%b expected busy=%b done=%b",
                                 x, n, busy_o[x][n], done_o[x][n], n <= k + WIN[x], n == k + WIN[x] + 1);
                    end
                    vecs++;
                    if (aq_o[x][n] !== m_hist[n-1]) begin
                        errs++;
                        $display("FAIL rand_aq dut%0d cyc%0d: got %h expected %h", x, n, aq_o[x][n], m_hist[n-1]);
                    end
                    if (n > k + WIN[x]) begin
                        vecs++;
                        if (cnt_o[x][n] !== exp_bus(k, WIN[x], CW[x])) begin
                            errs++;
                            $display("FAIL rand_cnt dut%0d cyc%0d: got %h expected %h", x, n, cnt_o[x][n], exp_bus(k, WIN[x], CW[x]));
                        end
`ifdef MASK_WINDOW_OVF_EN
                        vecs++;
                        if (ovf_o[x][n] !== exp_ovf(k, WIN[x], CW[x])) begin
                            errs++;
                            $display("FAIL rand_ovf dut%0d cyc%0d: got %b expected %b", x, n, ovf_o[x][n], exp_ovf(k, WIN[x], CW[x]));
                        end
`endif
                    end
                end
            end
        end
    endtask

    task automatic test_start_in_run();
        int k;
        int nd;
        run_window(3, 5, 10, k);
        for (int x = 0; x < 2; x++) begin
            nd = 0;
            for (int n = k + 1; n <= k + 20; n++) nd += int'(done_o[x][n]);
            vecs++;
            if (nd != 1 || done_o[x][k+17] !== 1'b1) begin
                errs++;
                $display("FAIL start_in_run_done dut%0d: got dones=%0d done@k+17=%b expected 1 1", x, nd, done_o[x][k+17]);
            end
            vecs++;
            if (cnt_o[x][k+17] !== exp_bus(k, 16, CW[x])) begin
                errs++;
                $display("FAIL start_in_run_cnt dut%0d: got %h expected %h", x, cnt_o[x][k+17], exp_bus(k, 16, CW[x]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int nd;
        k = cyc;
        for (int j = 0; j < 20; j++) begin
            drive(2, j);
            start = (j == 0);
            reset = (j == 8);
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        vecs++;
        if ({aq_o[0][k+9], busy_o[0][k+9], done_o[0][k+9], cnt_o[0][k+9]} !== '0) begin
            errs++;
            $display("FAIL reset_mid_state: got a_q=%h busy=%b done=%b cnt=%h expected all zero",
                     aq_o[0][k+9], busy_o[0][k+9], done_o[0][k+9], cnt_o[0][k+9]);
        end
        nd = 0;
        for (int n = k + 9; n <= k + 20; n++) nd += int'(done_o[0][n] | busy_o[0][n]);
        vecs++;
        if (nd != 0) begin
            errs++;
            $display("FAIL reset_mid_no_done: got %0d busy/done cycles expected 0", nd);
        end
        run_window(1, 0, 0, k);
        vecs++;
        if (done_o[0][k+17] !== 1'b1 || cnt_o[0][k+17] !== 16'h0101) begin
            errs++;
            $display("FAIL reset_mid_restart: got done=%b cnt=%h expected 1 0101", done_o[0][k+17], cnt_o[0][k+17]);
        end
    endtask

    initial begin
        test_reset();
        test_idle_mask();
        test_full_mask();
        test_toggle_saturation();
        test_random();
        test_start_in_run();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
